// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts a word over valid/ready and shifts it out one bit per CLKS_PER_BIT clocks,
// then pulses latchStrobe so the downstream shift stage can present the word.
module parallel_to_serial #(
  parameter int WIDTH = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             serialOut,
  output logic             shiftEnable,
  output logic             latchStrobe,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, sreg_sh;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DW-1:0] div, div_n;
  logic accept, tick;
  always_comb begin
    accept = (state == IDLE) && loadValid;
    tick = (state == SHIFT) && (div == LAST_DIV);
    sreg_sh = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    state_n = accept ? SHIFT : (tick && bcnt == LAST_BIT) ? LATCH : (state == LATCH) ? IDLE : state;
    sreg_n = accept ? dataIn : tick ? sreg_sh : sreg;
    bcnt_n = accept ? '0 : tick ? bcnt + BW'(1) : bcnt;
    div_n = (accept || tick) ? '0 : (state == SHIFT) ? div + DW'(1) : div;
  end
  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      bcnt <= '0;
      div <= '0;
      loadReady <= 1'b1;
      busy <= 1'b0;
      serialOut <= 1'b0;
      shiftEnable <= 1'b0;
      latchStrobe <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      bcnt <= bcnt_n;
      div <= div_n;
      loadReady <= state_n == IDLE;
      busy <= state_n != IDLE;
      serialOut <= (state_n == SHIFT) && (MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0]);
      shiftEnable <= (state_n == SHIFT) && (div_n == LAST_DIV);
      latchStrobe <= state_n == LATCH;
    end
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: three DUTs (C=1 MSB-first, C=3 MSB-first, C=1 LSB-first) checked by a scoreboard
// monitor that rebuilds each word through a downstream shift-register model.
module tb_parallel_to_serial;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst [3];
  logic lv [3];
  logic lr [3];
  logic so [3];
  logic se [3];
  logic ls [3];
  logic bz [3];
  logic [7:0] din [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    parallel_to_serial #(.WIDTH(8), .CLKS_PER_BIT(g == 1 ? 3 : 1), .MSB_FIRST(g != 2)) u_dut (
      .clock(clock), .reset(rst[g]), .dataIn(din[g]), .loadValid(lv[g]), .loadReady(lr[g]),
      .serialOut(so[g]), .shiftEnable(se[g]), .latchStrobe(ls[g]), .busy(bz[g])
    );
  end
  typedef struct {
    int inst;
    int t;
    logic [7:0] w;
  } exp_t;
  exp_t sb [$];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int nse [3] = '{0, 0, 0};
  logic [7:0] dn [3] = '{8'h00, 8'h00, 8'h00};
  logic prst [3] = '{1'b0, 1'b0, 1'b0};
  always @(posedge clock) cyc <= cyc + 1;
  function automatic int cpb(input int i);
    return i == 1 ? 3 : 1;
  endfunction
  function automatic bit msbf(input int i);
    return i != 2;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask
  // Monitor: sampled on the falling edge, pops the scoreboard on latchStrobe.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (cyc >= 2) begin
        int c;
        int k;
        bit have;
        exp_t e;
        c = cpb(i);
        have = sb.size() > 0 && sb[0].inst == i;
        if (prst[i]) begin
          chk($sformatf("u%0d_rst_busy", i), bz[i], 0);
          chk($sformatf("u%0d_rst_ready", i), lr[i], 1);
          chk($sformatf("u%0d_rst_serial", i), so[i], 0);
          chk($sformatf("u%0d_rst_shift", i), se[i], 0);
          chk($sformatf("u%0d_rst_latch", i), ls[i], 0);
        end
        chk($sformatf("u%0d_ready_vs_busy", i), lr[i], !bz[i]);
        if (!bz[i]) chk($sformatf("u%0d_idle_serial", i), so[i], 0);
        if ((bz[i] || se[i] || ls[i]) && !have) begin
          chk($sformatf("u%0d_unexpected_busy", i), bz[i], 0);
          chk($sformatf("u%0d_unexpected_shift", i), se[i], 0);
          chk($sformatf("u%0d_unexpected_latch", i), ls[i], 0);
        end else if (have) begin
          e = sb[0];
          if (bz[i] && !ls[i]) begin
            k = (cyc - e.t - 1) / c;
            if (cyc <= e.t || k > 7) chk($sformatf("u%0d_shift_window", i), bz[i], 0);
            else chk($sformatf("u%0d_bit%0d", i, k), so[i], msbf(i) ? e.w[7-k] : e.w[k]);
          end
          if (se[i]) begin
            chk($sformatf("u%0d_shift_time", i), cyc, e.t + (nse[i] + 1) * c);
            chk($sformatf("u%0d_shift_latch_excl", i), ls[i], 0);
            dn[i] = msbf(i) ? {dn[i][6:0], so[i]} : {so[i], dn[i][7:1]};
            nse[i]++;
          end
          if (ls[i]) begin
            chk($sformatf("u%0d_latch_time", i), cyc, e.t + 8 * c + 1);
            chk($sformatf("u%0d_pulse_count", i), nse[i], 8);
            chk($sformatf("u%0d_word", i), dn[i], e.w);
            chk($sformatf("u%0d_latch_serial", i), so[i], 0);
            void'(sb.pop_front());
            nse[i] = 0;
          end
        end
        if (rst[i] && sb.size() > 0 && sb[0].inst == i) void'(sb.pop_front());
        if (rst[i]) nse[i] = 0;
      end
      prst[i] = rst[i];
    end
  end
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask
  // Present a word and hold loadValid until accepted; returns the accepting cycle, leaves loadValid high.
  task automatic send(input int i, input logic [7:0] w, output int t);
    int n;
    n = 0;
    din[i] = w;
    lv[i] = 1'b1;
    while (!lr[i] && n < 100) begin
      next_cycle();
      n++;
    end
    chk($sformatf("u%0d_accept_wait", i), lr[i], 1);
    t = cyc;
    if (lr[i]) sb.push_back('{i, cyc, w});
    next_cycle();
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      next_cycle();
      n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
    repeat (3) next_cycle();
  endtask
  initial begin
    int t;
    int t1;
    int t2;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      lv[i] = 1'b0;
      din[i] = 8'h00;
    end
    repeat (3) next_cycle();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    next_cycle();
    send(0, 8'hA5, t);
    lv[0] = 1'b0;
    drain();
    send(1, 8'h3C, t);
    lv[1] = 1'b0;
    drain();
    send(2, 8'h01, t);
    lv[2] = 1'b0;
    drain();
    send(0, 8'hFF, t1);
    send(0, 8'h00, t2);
    lv[0] = 1'b0;
    chk("back_to_back_period", t2 - t1, 10);
    drain();
    send(0, 8'hF0, t);
    lv[0] = 1'b0;
    while (cyc < t + 4) next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    repeat (12) next_cycle();
    chk("abort_no_pending", sb.size(), 0);
    send(0, 8'h81, t);
    lv[0] = 1'b0;
    drain();
    send(0, 8'h5A, t);
    lv[0] = 1'b0;
    while (cyc < t + 9) next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    drain();
    send(1, 8'hC6, t);
    lv[1] = 1'b0;
    drain();
    din[0] = 8'hC3;
    lv[0] = 1'b1;
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    lv[0] = 1'b0;
    chk("coincident_busy", bz[0], 0);
    chk("coincident_ready", lr[0], 1);
    repeat (15) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Parallel-to-serial driver that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time. It sits directly upstream of the serial-to-parallel shift register stage. `serialOut` feeds its `dataIn`, `shiftEnable` qualifies each bit, and `latchStrobe` marks the end of a complete word so the downstream stage can present its parallel outputs. It also provides a programmable bit period so slow downstream logic can be driven from the system clock.

## Interface
- WIDTH, 8: word length in bits; ≥ 2.
- CLKS_PER_BIT, 1: system clocks per serial bit; ≥ 1.
- MSB_FIRST, 1: 1 = bit WIDTH-1 shifted first; 0 = bit 0 first.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  WIDTH  parallel word; sampled only on an accepting edge.
- loadValid  in  1  upstream has a word on `dataIn`.
- loadReady  out  1  block can accept a word; high only in IDLE.
- serialOut  out  1  current serial bit.
- shiftEnable  out  1  one-cycle pulse; downstream samples `serialOut` on this cycle's edge.
- latchStrobe  out  1  one-cycle pulse after the last bit of a word.
- busy  out  1  high in SHIFT or LATCH.

## Operation
- FSM states: IDLE, SHIFT, LATCH. Registers: shift register (WIDTH), bit counter (clog2(WIDTH+1)), divider counter (clog2(CLKS_PER_BIT)+1).
- IDLE:
  - `loadReady`=1, `busy`=0, `serialOut`=0.
  - On an edge with `loadValid` && `loadReady`: capture `dataIn`, clear both counters, go to SHIFT.
- SHIFT:
  - `serialOut` is the shift-register MSB when MSB_FIRST=1, else its LSB.
  - The divider counts 0..CLKS_PER_BIT-1. `shiftEnable`=1 when divider = CLKS_PER_BIT-1.
  - On that edge: shift the register by one toward the output end (zero fill), increment the bit counter, and clear the divider.
  - When the pulse is the WIDTH-th: go to LATCH.
- LATCH: `latchStrobe`=1 for exactly one cycle, `serialOut`=0, then go to IDLE.
- `loadValid` outside IDLE is ignored. `dataIn` is not sampled and no state changes. Upstream holds `loadValid` until it sees `loadReady`.
- `shiftEnable` and `latchStrobe` are never high in the same cycle.
- Exactly WIDTH `shiftEnable` pulses per accepted word.

## Timing
- Let the accepting edge be at the end of cycle t, and C = CLKS_PER_BIT.
- Bit k (k = 0..WIDTH-1, in shift order) is on `serialOut` during cycles t+1+k·C through t+(k+1)·C.
- `shiftEnable` is high in cycle t+(k+1)·C.
- `latchStrobe` is high in cycle t+WIDTH·C+1.
- `loadReady` returns high in cycle t+WIDTH·C+2. The earliest next accepting edge ends that cycle, so word period = WIDTH·C+2 cycles.
- C=1: `shiftEnable` is high on every SHIFT cycle.
- Reset:
  - An edge with `reset`=1 forces IDLE and clears the shift register and both counters, overriding any handshake on the same edge.
  - From the next cycle: `serialOut`=0, `shiftEnable`=0, `latchStrobe`=0, `busy`=0, `loadReady`=1.
- Reset mid-word (SHIFT or LATCH): the word is aborted, with no further `shiftEnable` and no `latchStrobe`.
- Reset and `loadValid` on the same edge: the word is not accepted.
- All outputs are decoded from registered state only, with no combinational path from inputs to outputs.

## Test plan
- Basic, WIDTH=8, C=1, MSB_FIRST=1: accept 8'hA5 at edge t → `serialOut` = 1,0,1,0,0,1,0,1 on the 8 `shiftEnable` cycles t+1..t+8. `latchStrobe` at t+9, `loadReady` at t+10. Downstream register model reads 8'hA5.
- Divider, C=3: accept 8'h3C → `shiftEnable` at t+3, t+6, …, t+24, each bit stable for 3 cycles. `latchStrobe` at t+25.
- LSB first, MSB_FIRST=0: accept 8'h01 → first bit 1, remaining seven 0. `latchStrobe` at t+9.
- Back-to-back: `loadValid` held high with 8'hFF then 8'h00 → second accept exactly 10 cycles after the first. `loadValid` during busy has no effect. Downstream model reads 8'hFF then 8'h00.
- Reset mid-word: accept 8'hF0, assert `reset` at cycle t+4 → from t+5 all outputs at reset values, no `latchStrobe`. Next word 8'h81 shifts correctly.
- Reset coincident with `loadValid`: no acceptance. `busy`=0 and `loadReady`=1 on the following cycle.
